// File: rtl/axi_stream_traffic_sink.sv
// axi_stream_traffic_sink
// Stream consumer with a programmable on/off ready pattern. It accumulates
// the beat count, a modular checksum, the last accepted word and the min/max
// inter-beat gap, and raises done after target_beats accepted beats.
//
// state | meaning
// IDLE  | not accepting; stats held; waits for enable
// RUN   | ready pattern active; beats accepted and counted
// DONE  | target reached; not accepting until enable drops or clear
module axi_stream_traffic_sink #(
  parameter int DATA_WIDTH  = 40,
  parameter int COUNT_WIDTH = 32,
  parameter int GAP_WIDTH   = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   clear,
  input  logic [COUNT_WIDTH-1:0] target_beats,
  input  logic [7:0]             ready_on,
  input  logic [7:0]             ready_off,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [COUNT_WIDTH-1:0] beat_count,
  output logic [DATA_WIDTH-1:0]  checksum,
  output logic [DATA_WIDTH-1:0]  last_data,
  output logic [GAP_WIDTH-1:0]   min_gap,
  output logic [GAP_WIDTH-1:0]   max_gap,
  output logic                   done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [GAP_WIDTH-1:0]   GAP_ONE   = {{(GAP_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [GAP_WIDTH-1:0]   GAP_MAX   = {GAP_WIDTH{1'b1}};

  state_t                 state;
  state_t                 state_next;
  logic [7:0]             pat_cnt;
  logic [7:0]             on_len;
  logic [GAP_WIDTH-1:0]   gap_cnt;
  logic                   first_beat;
  logic                   accept;
  logic                   hit_target;

  // A beat counts only while running and not being aborted or cleared, so the
  // registered ready left over from the last RUN cycle never sneaks one in.
  assign accept     = in_valid && in_ready && (state == RUN) && enable && !clear;
  assign hit_target = (target_beats != '0) && ((beat_count + COUNT_ONE) == target_beats);
  assign on_len     = (ready_on == 8'd0) ? 8'd1 : ready_on;
  assign done       = (state == DONE);

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; clear overrides everything.
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (enable) state_next = RUN;
        RUN: begin
          if (!enable)                   state_next = IDLE;
          else if (accept && hit_target) state_next = DONE;
        end
        DONE:    if (!enable) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Ready pattern: pat_cnt is a down-counter of remaining cycles in the current
  // phase; phase lengths are sampled only when a phase ends.
  always_ff @(posedge clock) begin
    if (!reset) begin
      in_ready <= 1'b0;
      pat_cnt  <= 8'd0;
    end else if (state_next != RUN) begin
      in_ready <= 1'b0;
    end else if (state != RUN) begin
      in_ready <= 1'b1;
      pat_cnt  <= on_len - 8'd1;
    end else if (ready_off == 8'd0) begin
      in_ready <= 1'b1;
      pat_cnt  <= on_len - 8'd1;
    end else if (pat_cnt == 8'd0) begin
      in_ready <= !in_ready;
      pat_cnt  <= in_ready ? (ready_off - 8'd1) : (on_len - 8'd1);
    end else begin
      pat_cnt  <= pat_cnt - 8'd1;
    end
  end

  // Statistics and gap measurement; gaps count RUN cycles only.
  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      beat_count <= '0;
      checksum   <= '0;
      last_data  <= '0;
      min_gap    <= GAP_MAX;
      max_gap    <= '0;
      gap_cnt    <= '0;
      first_beat <= 1'b1;
    end else begin
      if (state == RUN && gap_cnt != GAP_MAX) gap_cnt <= gap_cnt + GAP_ONE;
      if (accept) begin
        beat_count <= beat_count + COUNT_ONE;
        checksum   <= checksum + in_data;
        last_data  <= in_data;
        gap_cnt    <= GAP_ONE;
        if (first_beat) begin
          first_beat <= 1'b0;
        end else begin
          if (gap_cnt < min_gap) min_gap <= gap_cnt;
          if (gap_cnt > max_gap) max_gap <= gap_cnt;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_stream_traffic_sink.sv
// Randomized and directed bench for axi_stream_traffic_sink against a
// transaction-level reference model (run-cycle index arithmetic for the ready
// pattern, run-edge timestamps for gaps).
module tb_axi_stream_traffic_sink;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] target_beats = '0;
  logic [7:0]  ready_on = 8'd1;
  logic [7:0]  ready_off = 8'd0;
  logic [39:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] beat_count;
  logic [39:0] checksum;
  logic [39:0] last_data;
  logic [15:0] min_gap;
  logic [15:0] max_gap;
  logic        done;

  axi_stream_traffic_sink dut (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear),
    .target_beats(target_beats), .ready_on(ready_on), .ready_off(ready_off),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .beat_count(beat_count), .checksum(checksum), .last_data(last_data),
    .min_gap(min_gap), .max_gap(max_gap), .done(done)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: 0 idle, 1 run, 2 done.
  int          m_state;
  int          m_k;
  bit          m_ready;
  logic [31:0] m_beat;
  logic [39:0] m_cks;
  logic [39:0] m_last;
  logic [15:0] m_min;
  logic [15:0] m_max;
  bit          m_first;
  longint      m_run_edges;
  longint      m_anchor;

  logic [39:0] src_q[$];
  bit          want_valid = 1'b0;

  task automatic m_clear_stats();
    m_beat = '0; m_cks = '0; m_last = '0;
    m_min = 16'hFFFF; m_max = '0; m_first = 1'b1;
  endtask

  task automatic m_reset();
    m_clear_stats();
    m_state = 0; m_k = 0; m_ready = 1'b0;
    m_run_edges = 0; m_anchor = 0;
  endtask

  task automatic compare_all();
    check("in_ready",   {63'd0, in_ready},   {63'd0, m_ready});
    check("beat_count", {32'd0, beat_count}, {32'd0, m_beat});
    check("checksum",   {24'd0, checksum},   {24'd0, m_cks});
    check("last_data",  {24'd0, last_data},  {24'd0, m_last});
    check("min_gap",    {48'd0, min_gap},    {48'd0, m_min});
    check("max_gap",    {48'd0, max_gap},    {48'd0, m_max});
    check("done",       {63'd0, done},       {63'd0, (m_state == 2)});
  endtask

  // One clock: present the head of the source queue, advance the model by the
  // rules of the stream contract, then compare after the edge.
  task automatic step();
    bit          xfer;
    int          nxt;
    int          on_l;
    longint      gap;
    logic [39:0] d;
    in_valid = want_valid && (src_q.size() > 0);
    in_data  = (src_q.size() > 0) ? src_q[0] : 40'd0;
    d        = in_data;
    xfer     = in_valid && m_ready && (m_state == 1) && enable && !clear;
    if (m_state == 1) m_run_edges++;
    nxt = m_state;
    if (clear) begin
      m_clear_stats();
      nxt = 0;
    end else begin
      if (xfer) begin
        m_beat = m_beat + 32'd1;
        m_cks  = m_cks + d;
        m_last = d;
        if (m_first) begin
          m_first = 1'b0;
        end else begin
          gap = m_run_edges - m_anchor;
          if (gap > 65535) gap = 65535;
          if (gap < m_min) m_min = 16'(gap);
          if (gap > m_max) m_max = 16'(gap);
        end
        m_anchor = m_run_edges;
      end
      case (m_state)
        0: if (enable) begin nxt = 1; m_k = 0; end
        1: begin
          if (!enable) nxt = 0;
          else if (xfer && target_beats != 0 && m_beat == target_beats) nxt = 2;
          else m_k++;
        end
        default: if (!enable) nxt = 0;
      endcase
    end
    m_state = nxt;
    on_l = (ready_on == 0) ? 1 : int'(ready_on);
    m_ready = (m_state == 1) &&
              (ready_off == 0 || (m_k % (on_l + int'(ready_off))) < on_l);
    @(posedge clock); #1;
    if (xfer) void'(src_q.pop_front());
    compare_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    m_reset();
    src_q.delete();
    reset = 1'b1;
    compare_all();
  endtask

  task automatic pulse_clear();
    clear = 1'b1; step(); clear = 1'b0;
  endtask

  task automatic push_rand(input int n);
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < n; i++) begin
      a = $urandom; b = $urandom;
      src_q.push_back({a[7:0], b});
    end
  endtask

  initial begin
    m_reset();
    do_reset();

    // 1: bounded run of 4 from 1..5 with continuous ready
    pulse_clear();
    target_beats = 4; ready_on = 1; ready_off = 0; want_valid = 1;
    for (int i = 1; i <= 5; i++) src_q.push_back(40'(i));
    enable = 1; steps(6);
    check("t1_beats", {32'd0, beat_count}, 64'd4);
    check("t1_cks", {24'd0, checksum}, 64'hA);
    check("t1_last", {24'd0, last_data}, 64'd4);
    check("t1_min", {48'd0, min_gap}, 64'd1);
    check("t1_max", {48'd0, max_gap}, 64'd1);
    check("t1_done", {63'd0, done}, 64'd1);
    check("t1_ready", {63'd0, in_ready}, 64'd0);
    check("t1_left", 64'(src_q.size()), 64'd1);
    enable = 0; steps(2); src_q.delete();

    // 2: ready pattern 2 on / 3 off, unbounded, 20 run cycles
    pulse_clear();
    target_beats = 0; ready_on = 2; ready_off = 3; push_rand(40);
    enable = 1; steps(21);
    check("t2_beats", {32'd0, beat_count}, 64'd8);
    check("t2_min", {48'd0, min_gap}, 64'd1);
    check("t2_max", {48'd0, max_gap}, 64'd4);
    enable = 0; steps(2); src_q.delete();

    // 3: generator-style alternating valid, 6 beats
    pulse_clear();
    target_beats = 6; ready_on = 1; ready_off = 0; push_rand(6);
    want_valid = 0; enable = 1; step();
    for (int i = 0; i < 12; i++) begin want_valid = (i % 2 == 0); step(); end
    check("t3_beats", {32'd0, beat_count}, 64'd6);
    check("t3_min", {48'd0, min_gap}, 64'd2);
    check("t3_max", {48'd0, max_gap}, 64'd2);
    check("t3_done", {63'd0, done}, 64'd1);
    want_valid = 1; enable = 0; steps(2); src_q.delete();

    // 4: checksum wrap
    pulse_clear();
    target_beats = 2; src_q.push_back(40'hFF_FFFF_FFFF); src_q.push_back(40'h2);
    enable = 1; steps(4);
    check("t4_cks", {24'd0, checksum}, 64'h1);
    check("t4_done", {63'd0, done}, 64'd1);
    enable = 0; steps(2); src_q.delete();

    // 5: clear coincident with a transfer
    pulse_clear();
    target_beats = 0; push_rand(10);
    enable = 1; steps(3);
    clear = 1; step(); clear = 0;
    check("t5_beats", {32'd0, beat_count}, 64'd0);
    check("t5_cks", {24'd0, checksum}, 64'd0);
    check("t5_min", {48'd0, min_gap}, 64'hFFFF);
    check("t5_max", {48'd0, max_gap}, 64'd0);
    check("t5_ready", {63'd0, in_ready}, 64'd0);
    enable = 0; steps(2); src_q.delete();

    // 6: pause mid-run, resume toward same target
    pulse_clear();
    target_beats = 10; push_rand(10);
    enable = 1; steps(4);
    check("t6_beats3", {32'd0, beat_count}, 64'd3);
    enable = 0; steps(5);
    check("t6_hold", {32'd0, beat_count}, 64'd3);
    enable = 1; steps(8);
    check("t6_beats", {32'd0, beat_count}, 64'd10);
    check("t6_done", {63'd0, done}, 64'd1);
    check("t6_max_small", {63'd0, (max_gap < 16'd5)}, 64'd1);
    enable = 0; steps(2); src_q.delete();

    // Random segments with occasional clear, aborts and mid-run reset
    for (int s = 0; s < 30; s++) begin
      int prob;
      enable = 0; want_valid = 0; steps(2);
      if ($urandom_range(0, 9) == 0) do_reset();
      ready_on     = 8'($urandom_range(0, 3));
      ready_off    = 8'($urandom_range(0, 3));
      target_beats = $urandom_range(0, 12);
      prob         = $urandom_range(30, 100);
      push_rand(60);
      enable = 1;
      for (int c = 0; c < 60; c++) begin
        want_valid = ($urandom_range(0, 99) < prob);
        clear      = ($urandom_range(0, 39) == 0);
        if ($urandom_range(0, 29) == 0) enable = ~enable;
        step();
        clear = 0;
      end
      src_q.delete();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_stream_traffic_sink.md
Name: axi_stream_traffic_sink

Overview:
- Downstream consumer for the 40-bit traffic generator stream. Used in bring-up and benches.
- Accepts beats under a programmable on/off backpressure pattern and accumulates statistics: beat count, modular checksum, last word, and min/max inter-beat gap.
- Stops accepting after a programmed number of beats and raises done.
- Provides observable, repeatable stream throughput and integrity figures.

Parameters:
DATA_WIDTH, 40, stream word width
COUNT_WIDTH, 32, width of beat counter and target_beats
GAP_WIDTH, 16, width of gap measurement registers (saturating)

Ports:
clock  in  1  system clock
reset  in  1  reset
enable  in  1  run request; low aborts to IDLE
clear  in  1  one-cycle pulse; zeroes statistics, returns to IDLE
target_beats  in  COUNT_WIDTH  beats to accept before done; 0 = unbounded
ready_on  in  8  cycles in_ready is high per pattern period; 0 treated as 1
ready_off  in  8  cycles in_ready is low per pattern period; 0 = continuous ready
in_data  in  DATA_WIDTH  stream data
in_valid  in  1  stream valid
in_ready  out  1  stream ready (registered)
beat_count  out  COUNT_WIDTH  accepted beats
checksum  out  DATA_WIDTH  sum of accepted words mod 2^DATA_WIDTH
last_data  out  DATA_WIDTH  most recent accepted word
min_gap  out  GAP_WIDTH  smallest cycle distance between consecutive accepts
max_gap  out  GAP_WIDTH  largest cycle distance between consecutive accepts
done  out  1  high in DONE state

Behaviour:
- Interface: reset reset, synchronous, active-low; clock clock.
- Reset values: in_ready=0, beat_count=0, checksum=0, last_data=0, min_gap=all ones, max_gap=0, done=0, state=IDLE, pattern counter=0, gap counter=0, first-beat flag=1.
- Transfer occurs on any rising edge with in_valid && in_ready. in_valid may drop without a transfer (the generator pulses valid for one cycle); the sink tolerates this and never requires valid to hold.
- Stats update on the edge of the transfer; outputs are registered, 1-cycle latency:
  - beat_count += 1, wrapping at 2^COUNT_WIDTH.
  - checksum += in_data, truncated to DATA_WIDTH.
  - last_data = in_data.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN when enable=1 and clear=0. Stats are not cleared on entry; they accumulate across runs until clear.
  - RUN -> DONE on the edge where a transfer makes beat_count+1 == target_beats (target_beats != 0). That beat is counted.
  - RUN -> IDLE when enable=0. in_ready drops next cycle. No transfer on that edge, because in_ready was the registered value and the state exits.
  - DONE -> IDLE when enable=0 or clear=1. DONE ignores enable=1 (no re-arm without enable low).
  - clear=1 in any state: stats to reset values, state IDLE, in_ready=0. Clear wins over a simultaneous transfer; the beat is discarded.
- in_ready pattern, RUN only:
  - Pattern counter cycles through ready_on high cycles, then ready_off low cycles.
  - ready_off=0 gives in_ready constantly 1.
  - Counter restarts at the high phase on each IDLE->RUN.
  - in_ready=0 in IDLE and DONE, and on the cycle the DONE transition is registered.
  - ready_on/ready_off are sampled live; a change takes effect at the next phase boundary.
- Gap measurement:
  - Gap counter increments every cycle in RUN, saturating at 2^GAP_WIDTH-1, and reloads to 1 on a transfer.
  - The first transfer after clear/reset only clears the first-beat flag.
  - Later transfers compare the current gap counter value: min_gap = min(min_gap, gap); max_gap = max(max_gap, gap).
  - Back-to-back transfers give gap=1.
  - The gap counter holds in IDLE/DONE, so gaps spanning a pause include only RUN cycles.
- enable low mid-run followed by enable high resumes counting toward the same target_beats.
- Reset mid-operation behaves identically to power-on reset.

Test Plan:
1. target_beats=4, ready_off=0, valid every cycle with data 1,2,3,4,5 -> beat_count=4, checksum=0x000000000A, last_data=4, min_gap=max_gap=1, done=1, in_ready=0; fifth word not accepted.
2. ready_on=2, ready_off=3, valid held high, target=0 -> in_ready pattern 1,1,0,0,0 repeating; over 20 cycles beat_count=8, min_gap=1, max_gap=4.
3. Generator-style stimulus (valid one cycle, then low one cycle), ready_off=0, 6 beats -> min_gap=max_gap=2, beat_count=6.
4. Checksum wrap: two beats 0xFFFFFFFFFF and 0x0000000002 -> checksum=0x0000000001.
5. clear asserted on the same cycle as a transfer in RUN -> stats at reset values, min_gap=0xFFFF, state IDLE, in_ready=0 next cycle.
6. target=10, enable dropped after 3 beats for 5 cycles, then re-raised -> beat_count holds 3 while low; done after 7 further beats; max_gap excludes the 5 idle cycles.
